// File: rtl/fpu_pkg.sv
// Shared FPU definitions: float format, status codes, converter states.
// Used by int2fp_conv and int2fp_pack.
package fpu_pkg;

  localparam int EXP_W  = 10;
  localparam int MANT_W = 21;
  localparam int BIAS   = 511;

  // Exponent of a magnitude whose leading one sits at bit 31.
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + 31);

  localparam logic [3:0] EXACT     = 4'd0;
  localparam logic [3:0] OVERFLOW  = 4'd1;
  localparam logic [3:0] UNDERFLOW = 4'd2;
  localparam logic [3:0] INEXACT   = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_NORM,
    S_PACK,
    S_DONE
  } conv_state_e;

endpackage

// File: rtl/int2fp_pack.sv
// Maps sign, normalized magnitude and shift count to {float, status}.
// INT2FP_ROUND_EN selects round-nearest-even instead of truncation.
module int2fp_pack
  import fpu_pkg::*;
(
  input  logic        sign,
  input  logic [31:0] mag,
  input  logic [4:0]  lz,
  output logic [31:0] fp,
  output logic [3:0]  status
);

  logic [EXP_W-1:0]  exp_v;
  logic [MANT_W-1:0] mant_v;
  logic              lost;

  always_comb begin
    exp_v  = EXP_TOP - EXP_W'(lz);
    mant_v = mag[30:10];
    lost   = |mag[9:0];
`ifdef INT2FP_ROUND_EN
    if (mag[9] && ((|mag[8:0]) || mag[10])) begin
      if (&mant_v) begin
        mant_v = '0;
        exp_v  = exp_v + 1'b1;
      end else begin
        mant_v = mant_v + 1'b1;
      end
    end
`endif
    if (mag == 32'd0) begin
      fp     = '0;
      status = EXACT;
    end else begin
      fp     = {sign, exp_v, mant_v};
      status = lost ? INEXACT : EXACT;
    end
  end

endmodule

// File: rtl/int2fp_conv.sv
// int32 -> FPU float converter, one normalize shift per cycle.
// Optional INT2FP_ROUND_EN enables round-nearest-even in int2fp_pack.
module int2fp_conv
  import fpu_pkg::*;
(
  input  logic        clock_100Khz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] float_out,
  output logic [3:0]  status_out
);

  conv_state_e state;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [4:0]  lz_q;
  logic [31:0] fp_d;
  logic [3:0]  st_d;

  int2fp_pack u_pack (
    .sign   (sign_q),
    .mag    (mag_q),
    .lz     (lz_q),
    .fp     (fp_d),
    .status (st_d)
  );

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      lz_q       <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      float_out  <= '0;
      status_out <= EXACT;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            mag_q    <= int_in;
            sign_q   <= int_in[31];
            in_ready <= 1'b0;
            state    <= S_ABS;
          end
        end
        S_ABS: begin
          // -0x80000000 wraps to itself, which is the right magnitude
          mag_q <= sign_q ? (~mag_q + 32'd1) : mag_q;
          lz_q  <= '0;
          state <= (mag_q == 32'd0) ? S_PACK : S_NORM;
        end
        S_NORM: begin
          if (!mag_q[31]) begin
            mag_q <= {mag_q[30:0], 1'b0};
            lz_q  <= lz_q + 5'd1;
          end else begin
            state <= S_PACK;
          end
        end
        S_PACK: begin
          float_out  <= fp_d;
          status_out <= st_d;
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int2fp_conv.sv
// Scoreboard bench for int2fp_conv: value, status, latency,
// backpressure and mid-conversion reset.
module tb_int2fp_conv;

  logic        clock_100Khz = 1'b0;
  logic        reset        = 1'b0;
  logic        in_valid     = 1'b0;
  logic        out_ready    = 1'b1;
  logic [31:0] int_in       = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] float_out;
  logic [3:0]  status_out;

  int2fp_conv dut (
    .clock_100Khz (clock_100Khz),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .int_in       (int_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .float_out    (float_out),
    .status_out   (status_out)
  );

  always #5 clock_100Khz = ~clock_100Khz;

  typedef struct {
    logic [31:0] fp;
    logic [3:0]  st;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x);
    exp_t        e;
    logic [31:0] m;
    logic [9:0]  ex;
    logic [20:0] mt;
    int          p;
    e.fp  = '0;
    e.st  = 4'd0;
    e.lat = 2;
    if (x == 32'd0) return e;
    m = x[31] ? -x : x;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    m  = m << (31 - p);
    ex = 10'(511 + p);
    mt = m[30:10];
`ifdef INT2FP_ROUND_EN
    if (m[9] && (m[8:0] != 9'd0 || m[10])) {ex, mt} = {ex, mt} + 31'd1;
`endif
    e.fp  = {x[31], ex, mt};
    e.st  = (m[9:0] != 10'd0) ? 4'd3 : 4'd0;
    e.lat = 34 - p;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] f, input logic [3:0] s,
                              input int l);
    exp_t e;
    e.fp  = f;
    e.st  = s;
    e.lat = l;
    return e;
  endfunction

  task automatic convert(input string tag, input logic [31:0] x,
                         input exp_t e, input int hold);
    exp_t w;
    int   n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock_100Khz);
      n++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    int_in    = x;
    in_valid  = 1'b1;
    sb.push_back(e);
    @(posedge clock_100Khz);
    @(negedge clock_100Khz);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clock_100Khz);
      n++;
      @(negedge clock_100Khz);
    end while (!out_valid && n < 60);
    w = sb.pop_front();
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_fp"}, float_out, w.fp);
    check({tag, "_st"}, 32'(status_out), 32'(w.st));
    check({tag, "_lat"}, 32'(n), 32'(w.lat));
    for (int c = 0; c < hold; c++) begin
      int_in   = 32'h0001_2345;
      in_valid = (c == 1);
      @(posedge clock_100Khz);
      @(negedge clock_100Khz);
      check({tag, "_bp_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_bp_fp"}, float_out, w.fp);
      check({tag, "_bp_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock_100Khz);
    @(negedge clock_100Khz);
    check({tag, "_post_vld"}, 32'(out_valid), 32'd0);
    check({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
    check({tag, "_post_fp"}, float_out, w.fp);
  endtask

  logic [31:0] vec;

  initial begin
    repeat (3) @(negedge clock_100Khz);
    check("rst_fp", float_out, 32'h0);
    check("rst_st", 32'(status_out), 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(negedge clock_100Khz);
    check("rst_rdy", 32'(in_ready), 32'd1);

    convert("one", 32'd1, mk(32'h3FE0_0000, 4'd0, 34), 0);
    convert("neg6", 32'hFFFF_FFFA, mk(32'hC030_0000, 4'd0, 32), 0);
    convert("zero", 32'd0, mk(32'h0, 4'd0, 2), 0);
    convert("min", 32'h8000_0000, mk(32'hC3C0_0000, 4'd0, 3), 0);
`ifdef INT2FP_ROUND_EN
    convert("max", 32'h7FFF_FFFF, mk(32'h43C0_0000, 4'd3, 4), 0);
`else
    convert("max", 32'h7FFF_FFFF, mk(32'h43BF_FFFF, 4'd3, 4), 0);
`endif
    convert("tie", 32'h0000_0600 | 32'h0020_0000,
            model(32'h0020_0600), 0);
    convert("m1", 32'hFFFF_FFFF, model(32'hFFFF_FFFF), 0);
    for (int i = 0; i < 8; i++) begin
      vec = $urandom;
      if (i[0]) vec = vec >> $urandom_range(0, 31);
      convert($sformatf("rnd%0d", i), vec, model(vec), 0);
    end
    convert("bp", 32'hFFFF_FFFA, mk(32'hC030_0000, 4'd0, 32), 5);

    check("pre_rst_fp", 32'(float_out != 32'h0), 32'd1);
    int_in   = 32'd1;
    in_valid = 1'b1;
    @(posedge clock_100Khz);
    @(negedge clock_100Khz);
    in_valid = 1'b0;
    repeat (10) @(negedge clock_100Khz);
    reset = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    check("mid_rst_fp", float_out, 32'h0);
    check("mid_rst_st", 32'(status_out), 32'd0);
    @(negedge clock_100Khz);
    reset = 1'b1;
    @(negedge clock_100Khz);
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    repeat (40) @(negedge clock_100Khz);
    check("mid_rst_idle", 32'(out_valid), 32'd0);
    convert("after", 32'd100, model(32'd100), 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
